// File: rtl/i2c_response_packet_fifo.sv
// Packet-committing response byte FIFO: the I2C controller writes bytes speculatively and
// then commits or aborts them; the reader sees only committed bytes, each with a last-byte marker.
module i2c_response_packet_fifo #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [7:0]            wr_dat_i,
    input  logic                  wr_i,
    input  logic                  packet_i,
    input  logic                  abort_i,
    output logic                  full_o,
    output logic [7:0]            rd_dat_o,
    output logic                  rd_last_o,
    input  logic                  rd_i,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   pkt_count_o,
    output logic [7:0]            drop_count_o
);

    localparam int AW    = DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {AW{1'b0}}};

    logic [8:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_cmt_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_ovf;
    logic [PW-1:0] r_pkt_count;
    logic [7:0]    r_drop_count;

    logic          w_full;
    logic          w_empty;
    logic          w_commit;
    logic          w_wr_ok;
    logic          w_wr_ovf;
    logic          w_ovf_eff;
    logic [PW-1:0] w_wr_ptr_inc;
    logic          w_cmt_ok;
    logic          w_drop;
    logic          w_rd_ok;
    logic [8:0]    w_head;
    logic          w_pop_last;
    logic [AW-1:0] w_last_idx;
    logic [PW-1:0] w_pkt_nxt;

    // Uncommitted bytes occupy space, so fullness is measured from the speculative pointer.
    assign w_full       = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
    assign w_empty      = (r_cmt_ptr == r_rd_ptr);
    assign w_commit     = packet_i & ~abort_i;
    assign w_wr_ok      = wr_i & ~w_full & ~abort_i;
    assign w_wr_ovf     = wr_i & w_full & ~abort_i;
    // A byte lost in the commit cycle itself also spoils the packet.
    assign w_ovf_eff    = r_ovf | w_wr_ovf;
    assign w_wr_ptr_inc = w_wr_ok ? (r_wr_ptr + {{AW{1'b0}}, 1'b1}) : r_wr_ptr;
    assign w_cmt_ok     = w_commit & ~w_ovf_eff & (w_wr_ptr_inc != r_cmt_ptr);
    assign w_drop       = w_commit & w_ovf_eff;
    assign w_rd_ok      = rd_i & ~w_empty;
    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop_last   = w_rd_ok & w_head[8];
    assign w_last_idx   = r_wr_ptr[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

    assign full_o       = w_full;
    assign empty_o      = w_empty;
    assign rd_dat_o     = w_empty ? 8'h00 : w_head[7:0];
    assign rd_last_o    = w_empty ? 1'b0 : w_head[8];
    assign pkt_count_o  = r_pkt_count;
    assign drop_count_o = r_drop_count;

    // Packet counter next value; a commit and a last-byte pop in one cycle cancel out.
    always_comb begin
        w_pkt_nxt = r_pkt_count;
        case ({w_cmt_ok, w_pop_last})
            2'b10:   w_pkt_nxt = r_pkt_count + {{AW{1'b0}}, 1'b1};
            2'b01:   w_pkt_nxt = r_pkt_count - {{AW{1'b0}}, 1'b1};
            default: w_pkt_nxt = r_pkt_count;
        endcase
    end

    // Byte storage (not reset); a commit without a same-cycle byte marks the previous byte last.
    always_ff @(posedge clk_i) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {packet_i, wr_dat_i};
        end
        if (w_cmt_ok && !w_wr_ok) begin
            r_mem[w_last_idx][8] <= 1'b1;
        end
    end

    // Pointers, overflow flag and counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr     <= {PW{1'b0}};
            r_cmt_ptr    <= {PW{1'b0}};
            r_rd_ptr     <= {PW{1'b0}};
            r_ovf        <= 1'b0;
            r_pkt_count  <= {PW{1'b0}};
            r_drop_count <= 8'h00;
        end else begin
            if (abort_i) begin
                r_wr_ptr <= r_cmt_ptr;
                r_ovf    <= 1'b0;
            end else if (w_drop) begin
                r_wr_ptr <= r_cmt_ptr;
                r_ovf    <= 1'b0;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'h01;
                end else begin
                    r_drop_count <= r_drop_count;
                end
            end else begin
                r_wr_ptr <= w_wr_ptr_inc;
                if (w_wr_ovf) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_ovf <= r_ovf;
                end
                if (w_cmt_ok) begin
                    r_cmt_ptr <= w_wr_ptr_inc;
                end else begin
                    r_cmt_ptr <= r_cmt_ptr;
                end
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_pkt_count <= w_pkt_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_response_packet_fifo.sv
// Bench for i2c_response_packet_fifo: directed stimulus feeds an expected-byte queue,
// and a negedge monitor pops and compares every byte the FIFO hands out.
module tb_i2c_response_packet_fifo;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [7:0] wr_dat_i = 8'h00;
    logic       wr_i = 1'b0;
    logic       packet_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       full_o;
    logic [7:0] rd_dat_o;
    logic       rd_last_o;
    logic       rd_i = 1'b0;
    logic       empty_o;
    logic [6:0] pkt_count_o;
    logic [7:0] drop_count_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_q[$];
    logic [8:0] pend_q[$];

    i2c_response_packet_fifo #(.DEPTH_LOG2(6)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_dat_i(wr_dat_i), .wr_i(wr_i),
        .packet_i(packet_i), .abort_i(abort_i), .full_o(full_o), .rd_dat_o(rd_dat_o),
        .rd_last_o(rd_last_o), .rd_i(rd_i), .empty_o(empty_o),
        .pkt_count_o(pkt_count_o), .drop_count_o(drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Move pending speculative bytes to the expected stream, marking the final one last.
    task automatic finalize();
        if (pend_q.size() > 0) begin
            pend_q[pend_q.size()-1][8] = 1'b1;
            foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
            pend_q.delete();
        end
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic pkt, input logic keep);
        wr_i = 1'b1;
        wr_dat_i = d;
        packet_i = pkt;
        if (keep) pend_q.push_back({1'b0, d});
        if (pkt) finalize();
        tick();
        wr_i = 1'b0;
        packet_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        rd_i = 1'b1;
        while (!empty_o && n < 200) begin
            tick();
            n++;
        end
        rd_i = 1'b0;
        chk({name, "_drain_timeout"}, int'(n >= 200), 0);
        tick();
        chk({name, "_exp_left"}, exp_q.size(), 0);
    endtask

    // Monitor: a byte is handed out at the next posedge whenever rd_i is high and data is present.
    always @(negedge clk_i) begin
        if (rst_n_i && rd_i && !empty_o) begin
            logic [8:0] e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %h/%0d expected no byte", rd_dat_o, rd_last_o);
            end else begin
                e = exp_q.pop_front();
                if (rd_dat_o != e[7:0] || rd_last_o != e[8]) begin
                    n_fail++;
                    $display("FAIL pop_byte: got %h/%0d expected %h/%0d", rd_dat_o, rd_last_o, e[7:0], e[8]);
                end
            end
        end
    end

    initial begin
        int full_cnt;
        int false_empty;
        logic [7:0] d;

        #1;
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_rd_dat", rd_dat_o, 0);
        chk("rst_pkt", pkt_count_o, 0);
        #20 rst_n_i = 1'b1;
        tick();

        // 1: basic three-byte packet
        wr_byte(8'h11, 1'b0, 1'b1);
        chk("t1_empty_b1", empty_o, 1);
        wr_byte(8'h22, 1'b0, 1'b1);
        chk("t1_empty_b2", empty_o, 1);
        wr_byte(8'h33, 1'b1, 1'b1);
        chk("t1_empty_after_cmt", empty_o, 0);
        chk("t1_pkt1", pkt_count_o, 1);
        drain("t1");
        chk("t1_pkt0", pkt_count_o, 0);
        chk("t1_empty_end", empty_o, 1);

        // 2: abort discards pending bytes, then a one-byte packet
        for (int i = 0; i < 5; i++) wr_byte(8'(i + 1), 1'b0, 1'b1);
        abort_i = 1'b1;
        pend_q.delete();
        tick();
        abort_i = 1'b0;
        wr_byte(8'hAA, 1'b1, 1'b1);
        chk("t2_pkt", pkt_count_o, 1);
        drain("t2");
        chk("t2_drop", drop_count_o, 0);

        // 3: overflow drops the whole packet
        for (int i = 0; i < 70; i++) begin
            wr_byte(8'(i), 1'b0, 1'b0);
            if (i == 62) chk("t3_full_63", full_o, 0);
            if (i == 63) chk("t3_full_64", full_o, 1);
        end
        packet_i = 1'b1;
        tick();
        packet_i = 1'b0;
        chk("t3_drop", drop_count_o, 1);
        chk("t3_empty", empty_o, 1);
        chk("t3_full", full_o, 0);
        chk("t3_pkt", pkt_count_o, 0);

        // 4: commit coinciding with a last-byte pop
        wr_byte(8'hA1, 1'b0, 1'b1);
        wr_byte(8'hA2, 1'b1, 1'b1);
        wr_byte(8'hB1, 1'b0, 1'b1);
        wr_byte(8'hB2, 1'b1, 1'b1);
        chk("t4_pkt2", pkt_count_o, 2);
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        wr_byte(8'hC1, 1'b0, 1'b1);
        packet_i = 1'b1;
        rd_i = 1'b1;
        finalize();
        tick();
        packet_i = 1'b0;
        rd_i = 1'b0;
        chk("t4_pkt_same", pkt_count_o, 2);
        drain("t4");
        chk("t4_pkt0", pkt_count_o, 0);

        // 5: stream 300 bytes as 4-byte packets with continuous reads, crossing the pointer wrap
        full_cnt = 0;
        false_empty = 0;
        rd_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            d = 8'(i) ^ 8'h5A;
            wr_i = 1'b1;
            wr_dat_i = d;
            packet_i = (i % 4 == 3);
            pend_q.push_back({1'b0, d});
            if (i % 4 == 3) finalize();
            tick();
            if (full_o) full_cnt++;
            if ((i % 4 == 3) && empty_o) false_empty++;
        end
        wr_i = 1'b0;
        packet_i = 1'b0;
        chk("t5_false_full", full_cnt, 0);
        chk("t5_false_empty", false_empty, 0);
        drain("t5");
        chk("t5_pkt0", pkt_count_o, 0);

        // 6: asynchronous reset mid-packet and mid-read
        wr_byte(8'hC3, 1'b0, 1'b1);
        wr_byte(8'h3C, 1'b1, 1'b1);
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        wr_byte(8'h99, 1'b0, 1'b1);
        chk("t6_head_pre", rd_dat_o, 8'h3C);
        #2 rst_n_i = 1'b0;
        #1;
        chk("t6_rst_empty", empty_o, 1);
        chk("t6_rst_rd_dat", rd_dat_o, 0);
        chk("t6_rst_last", rd_last_o, 0);
        chk("t6_rst_pkt", pkt_count_o, 0);
        chk("t6_rst_drop", drop_count_o, 0);
        chk("t6_rst_full", full_o, 0);
        exp_q.delete();
        pend_q.delete();
        tick();
        rst_n_i = 1'b1;
        tick();
        wr_byte(8'h7E, 1'b0, 1'b1);
        wr_byte(8'h81, 1'b1, 1'b1);
        chk("t6_pkt", pkt_count_o, 1);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
